imem_loader: RTL and testbench

Write-side companion to the instruction memory: receives a framed byte stream over a valid/ready handshake and writes the payload into the 32-entry x 16-bit instruction store. Each pair of bytes becomes one little-endian 16-bit entry. A trailing XOR checksum validates the frame. The core is held off for the duration of a load.

---
 rtl/imem_pkg.sv | 7 +
 rtl/imem_loader.sv | 87 ++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared instruction-memory geometry and loader state encoding
package imem_pkg;
    localparam int DEPTH = 32;
    localparam int ADDR_W = 5;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    typedef enum logic [2:0] {IDLE, COUNT, LO, HI, WRITE, CHECK} state_t;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader writing 16-bit little-endian entries
// into the instruction store, with XOR checksum and core hold during a load.
module imem_loader
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);
    state_t          state;
    logic [ADDR_W:0] n;
    logic [ADDR_W:0] idx;
    logic [7:0]      lo;
    logic [7:0]      csum;
    logic            acc;

    assign acc = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            idx       <= '0;
            lo        <= '0;
            csum      <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_hold <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            in_ready  <= 1'b1;
            // lags the state by one cycle, so it drops just after returning to IDLE
            core_hold <= state != IDLE;
            case (state)
                IDLE: if (acc && in_data == SYNC_BYTE) state <= COUNT;
                COUNT: if (acc) begin
                    if (in_data == 8'd0 || in_data > 8'(DEPTH)) begin
                        load_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        n     <= in_data[ADDR_W:0];
                        idx   <= '0;
                        csum  <= '0;
                        state <= LO;
                    end
                end
                LO: if (acc) begin
                    lo    <= in_data;
                    csum  <= csum ^ in_data;
                    state <= HI;
                end
                HI: if (acc) begin
                    mem_wdata <= {in_data, lo};
                    mem_addr  <= idx[ADDR_W-1:0];
                    mem_we    <= 1'b1;
                    in_ready  <= 1'b0;
                    csum      <= csum ^ in_data;
                    state     <= WRITE;
                end
                WRITE: begin
                    idx   <= idx + 1'b1;
                    state <= (idx + 1'b1 == n) ? CHECK : LO;
                end
                CHECK: if (acc) begin
                    load_done <= in_data == csum;
                    load_err  <= in_data != csum;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with a write-capturing memory model
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    int we_cnt, done_cnt, err_cnt, both_cnt, hold_bad;
    logic [15:0] model [32];
    logic [4:0]  addr_q [$];
    time t_sync, t_acc;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_hold(core_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            model[mem_addr] = mem_wdata;
            addr_q.push_back(mem_addr);
            we_cnt++;
            if (!core_hold) hold_bad++;
        end
        if (load_done) done_cnt++;
        if (load_err) err_cnt++;
        if (load_done && load_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        we_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0; hold_bad = 0;
        addr_q.delete();
        for (int i = 0; i < 32; i++) model[i] = 16'h0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        bit ok = 0;
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        in_data = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        t_acc = $time;
        #1 in_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] q [$], input bit gap);
        foreach (q[i]) begin
            send(q[i], gap);
            if (i == 0) t_sync = t_acc;
        end
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] cs, lo, hi;
        int bad;
        clr();
        idle(3);
        chk("rst_outs", {in_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err},
            {1'b1, 1'b0, 5'd0, 16'd0, 3'b000});
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // N=2 good frame
        frame('{8'hA5, 8'h02, 8'h34}, 0);
        chk("hold_in_frame", core_hold, 1);
        frame('{8'h12, 8'h78, 8'h56, 8'h08}, 0);
        chk("done_latency", load_done, 1);
        chk("err_with_done", load_err, 0);
        idle(3);
        chk("n2_we_cnt", we_cnt, 2);
        chk("n2_entry0", model[0], 16'h1234);
        chk("n2_entry1", model[1], 16'h5678);
        chk("n2_done_cnt", done_cnt, 1);
        chk("n2_err_cnt", err_cnt, 0);
        chk("n2_hold_bad", hold_bad, 0);
        chk("n2_hold_idle", core_hold, 0);
        chk("n2_addr_hold", mem_addr, 5'd1);
        chk("n2_wdata_hold", mem_wdata, 16'h5678);

        // frame length with continuous valid: 3N+3 accepted/stall cycles
        clr();
        frame('{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h08}, 0);
        chk("frame_len", 32'((t_acc - t_sync) / 10 + 1), 9);
        idle(3);

        // bad checksum
        clr();
        frame('{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h09}, 0);
        chk("bad_cs_err_lat", load_err, 1);
        idle(3);
        chk("bad_cs_we_cnt", we_cnt, 2);
        chk("bad_cs_entry1", model[1], 16'h5678);
        chk("bad_cs_done", done_cnt, 0);
        chk("bad_cs_err", err_cnt, 1);

        // illegal counts
        clr();
        frame('{8'hA5, 8'h00}, 0);
        chk("cnt0_err_lat", load_err, 1);
        idle(2);
        frame('{8'hA5, 8'h21}, 0);
        chk("cnt21_err_lat", load_err, 1);
        idle(3);
        chk("badcnt_we", we_cnt, 0);
        chk("badcnt_err_cnt", err_cnt, 2);
        chk("badcnt_hold_idle", core_hold, 0);

        // count 32 is legal; garbage before sync; 0xA5 as data
        clr();
        frame('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'h3C, 8'h99}, 0);
        idle(3);
        chk("a5_we_cnt", we_cnt, 1);
        chk("a5_entry0", model[0], 16'h3CA5);
        chk("a5_done", done_cnt, 1);

        // full load with random gaps
        clr();
        q = '{8'hA5, 8'd32};
        cs = 8'h00;
        for (int i = 0; i < 32; i++) begin
            lo = 8'(i * 3 + 5);
            hi = 8'(i) ^ 8'h5A;
            q.push_back(lo);
            q.push_back(hi);
            cs = cs ^ lo ^ hi;
        end
        q.push_back(cs);
        frame(q, 1);
        idle(3);
        chk("full_we_cnt", we_cnt, 32);
        chk("full_q_size", addr_q.size(), 32);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (model[i] !== {8'(i) ^ 8'h5A, 8'(i * 3 + 5)}) bad++;
            if (i < addr_q.size() && addr_q[i] !== 5'(i)) bad++;
        end
        chk("full_bad_entries", bad, 0);
        chk("full_done", done_cnt, 1);
        chk("full_err", err_cnt, 0);
        chk("full_both", both_cnt, 0);

        // reset after lo byte of entry 1
        clr();
        frame('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33}, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {in_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err},
            {1'b1, 1'b0, 5'd0, 16'd0, 3'b000});
        idle(3);
        chk("midrst_we_cnt", we_cnt, 1);
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        clr();
        frame('{8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h66}, 0);
        idle(3);
        chk("post_rst_entry0", model[0], 16'hABCD);
        chk("post_rst_entry1", model[1], 16'h0000);
        chk("post_rst_done", done_cnt, 1);
        chk("post_rst_err", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
